// File: rtl/debounce_array.sv
// Multi-channel switch debouncer with optional auto-repeat.
// Each channel synchronises its raw input, only accepts a new level after
// THRESHOLD consecutive en ticks that disagree with the current level, and
// emits one-cycle rise/fall pulses plus optional held-key repeat pulses.

module debounce_lane #(
  parameter int THRESHOLD    = 48,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic fall,
  output logic rpt
);

  localparam int   CW   = $clog2(THRESHOLD + 1);
  // Raw pin value that means "not asserted"; synchronizer resets to it.
  localparam logic IDLE = (ACTIVE_LOW != 0);

  logic          sync1, sync2;
  logic          s;
  logic [CW-1:0] cnt;
  logic          accept;

  // Normalised sample: 1 means the channel is asserted.
  assign s      = sync2 ^ IDLE;
  // This en tick completes the disagreement run and flips the level.
  assign accept = en && (s != level) && (cnt == CW'(THRESHOLD - 1));

  // Two-flop synchronizer, clocked every cycle independent of en.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      sync1 <= IDLE;
      sync2 <= IDLE;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Disagreement counter and accepted level; edge pulses are registered
  // alongside the level so they line up with the level change.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      if (en) begin
        if (s == level) begin
          cnt <= '0;
        end else if (accept) begin
          level <= s;
          cnt   <= '0;
          rise  <= s;
          fall  <= ~s;
        end else begin
          cnt <= cnt + CW'(1);
        end
      end
    end
  end

  generate
    if (REPEAT_DELAY > 0) begin : g_rep
      localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
      localparam int RW   = $clog2(RMAX + 1);

      logic [RW-1:0] rcnt;
      logic [RW-1:0] rnxt;
      logic [RW-1:0] rlim;
      logic          armed;  // first repeat already issued; use RATE from now on

      assign rnxt = rcnt + RW'(1);
      assign rlim = armed ? RW'(REPEAT_RATE) : RW'(REPEAT_DELAY);

      // Repeat timer: counts en ticks while held, restarts from zero after
      // every pulse, so it never overflows however long the key is held.
      always_ff @(posedge clk) begin
        if (!rstn) begin
          rcnt  <= '0;
          armed <= 1'b0;
          rpt   <= 1'b0;
        end else begin
          rpt <= 1'b0;
          if (en) begin
            if (!level || accept) begin
              // Idle, rising this tick, or falling this tick: no repeat.
              rcnt  <= '0;
              armed <= 1'b0;
            end else if (rnxt == rlim) begin
              rpt   <= 1'b1;
              rcnt  <= '0;
              armed <= 1'b1;
            end else begin
              rcnt <= rnxt;
            end
          end
        end
      end
    end else begin : g_norep
      assign rpt = 1'b0;
    end
  endgenerate

endmodule

module debounce_array #(
  parameter int N            = 4,
  parameter int THRESHOLD    = 48,
  parameter int ACTIVE_LOW   = 1,
  parameter int REPEAT_DELAY = 0,
  parameter int REPEAT_RATE  = 8
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic [N-1:0] raw,
  output logic [N-1:0] level,
  output logic [N-1:0] rise,
  output logic [N-1:0] fall,
  output logic [N-1:0] rpt
);

  generate
    if (N < 1 || THRESHOLD < 1 || REPEAT_RATE < 1 || REPEAT_DELAY < 0) begin : g_bad_param
      $error("debounce_array: illegal parameter (N, THRESHOLD, REPEAT_RATE must be >= 1)");
    end
  endgenerate

  // One independent debouncer per channel.
  generate
    for (genvar i = 0; i < N; i++) begin : g_lane
      debounce_lane #(
        .THRESHOLD   (THRESHOLD),
        .ACTIVE_LOW  (ACTIVE_LOW),
        .REPEAT_DELAY(REPEAT_DELAY),
        .REPEAT_RATE (REPEAT_RATE)
      ) u_lane (
        .clk  (clk),
        .rstn (rstn),
        .en   (en),
        .raw  (raw[i]),
        .level(level[i]),
        .rise (rise[i]),
        .fall (fall[i]),
        .rpt  (rpt[i])
      );
    end
  endgenerate

endmodule
